control_sequencer: RTL

Hardwired control unit that sits directly upstream of the datapath and drives every datapath control strobe once per clock. It steps through fetch (T0-T2) and per-instruction execute steps (T3-T7) using the IR opcode and the memory handshake. It replaces the hand-scripted state sequence used in bring-up simulation.

---
 rtl/control_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2), decode, and per-class execute
// steps (T3-T7) that drive every datapath strobe from the current state.
module control_sequencer #(
  parameter int OPW         = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [31:0]    ir,
  input  logic           mem_ready,
  output logic           PCout,
  output logic           MARin,
  output logic           IncPC,
  output logic           PCin,
  output logic           Read,
  output logic           Write,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Yin,
  output logic           ZHIin,
  output logic           ZLOin,
  output logic           ZHighout,
  output logic           ZLowout,
  output logic           HIin,
  output logic           LOin,
  output logic           Cout,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic [OPW-1:0] operation,
  output logic           run,
  output logic           illegal_op,
  output logic           mem_err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [4:0] FETCH0  = 5'd0,  FETCH1  = 5'd1,  FETCH2  = 5'd2,
                         DECODE  = 5'd3,  A2_T3   = 5'd4,  A2_T4   = 5'd5,
                         A2_T5   = 5'd6,  MD_T3   = 5'd7,  MD_T4   = 5'd8,
                         MD_T5   = 5'd9,  MD_T6   = 5'd10, A1_T3   = 5'd11,
                         A1_T4   = 5'd12, LD_T3   = 5'd13, LD_T4   = 5'd14,
                         LD_T5   = 5'd15, LD_T6   = 5'd16, LD_T7   = 5'd17,
                         ST_T3   = 5'd18, ST_T4   = 5'd19, ST_T5   = 5'd20,
                         ST_T6   = 5'd21, ST_T7   = 5'd22, ILLEGAL = 5'd23,
                         HALT    = 5'd24;

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, pc_in, rd, wr, mdr_in, mdr_out, ir_in;
    logic y_in, zhi_in, zlo_in, zhigh_out, zlow_out, hi_in, lo_in, c_out;
    logic gra, grb, grc, r_in, r_out, ba_out;
  } strobes_t;

  logic [4:0]     state, state_nx;
  logic [4:0]     opcode;
  logic [CW-1:0]  wait_cnt;
  logic [OPW-1:0] op_q, op_dec;
  logic           in_wait, timeout, ill_dec;
  logic           unused_ir_bits;
  strobes_t       s, g;

  assign opcode         = ir[31:27];
  assign unused_ir_bits = ^ir[26:0];

  always_comb begin
    in_wait = state inside {FETCH1, LD_T6, ST_T7};
    timeout = in_wait && !mem_ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH0:  state_nx = FETCH1;
      FETCH1:  if (mem_ready) state_nx = FETCH2; else if (timeout) state_nx = HALT;
      FETCH2:  state_nx = DECODE;
      DECODE: begin
        case (opcode)
          5'b00011, 5'b00100, 5'b00101, 5'b00110,
          5'b00111, 5'b01000, 5'b01001, 5'b01010: state_nx = A2_T3;
          5'b01110, 5'b01111:                     state_nx = MD_T3;
          5'b10000, 5'b10001:                     state_nx = A1_T3;
          5'b00000:                               state_nx = LD_T3;
          5'b00010:                               state_nx = ST_T3;
          5'b11010:                               state_nx = FETCH0;
          5'b11011:                               state_nx = HALT;
          default:                                state_nx = ILLEGAL;
        endcase
      end
      A2_T3:   state_nx = A2_T4;
      A2_T4:   state_nx = A2_T5;
      MD_T3:   state_nx = MD_T4;
      MD_T4:   state_nx = MD_T5;
      MD_T5:   state_nx = MD_T6;
      A1_T3:   state_nx = A1_T4;
      LD_T3:   state_nx = LD_T4;
      LD_T4:   state_nx = LD_T5;
      LD_T5:   state_nx = LD_T6;
      LD_T6:   if (mem_ready) state_nx = LD_T7; else if (timeout) state_nx = HALT;
      ST_T3:   state_nx = ST_T4;
      ST_T4:   state_nx = ST_T5;
      ST_T5:   state_nx = ST_T6;
      ST_T6:   state_nx = ST_T7;
      ST_T7:   if (mem_ready) state_nx = FETCH0; else if (timeout) state_nx = HALT;
      HALT:    state_nx = HALT;
      default: state_nx = FETCH0;
    endcase
  end

  // Opcode is captured at DECODE so the ALU code comes from state alone.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= FETCH0;
      wait_cnt <= '0;
      op_q     <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= (in_wait && !mem_ready) ? wait_cnt + CW'(1) : '0;
      if (state == DECODE) op_q <= OPW'(opcode);
      mem_err  <= mem_err | timeout;
    end
  end

  always_comb begin
    s       = '0;
    op_dec  = '0;
    ill_dec = 1'b0;
    case (state)
      FETCH0:  begin s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.zlo_in = 1'b1; end
      FETCH1:  begin s.zlow_out = 1'b1; s.pc_in = 1'b1; s.rd = 1'b1; s.mdr_in = 1'b1; end
      FETCH2:  begin s.mdr_out = 1'b1; s.ir_in = 1'b1; end
      A2_T3, MD_T3: begin s.grb = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
      A2_T4, MD_T4: begin
        s.grc = 1'b1; s.r_out = 1'b1; s.zlo_in = 1'b1; op_dec = op_q;
        s.zhi_in = (state == MD_T4);
      end
      A2_T5, A1_T4: begin s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
      MD_T5:   begin s.zlow_out = 1'b1; s.lo_in = 1'b1; end
      MD_T6:   begin s.zhigh_out = 1'b1; s.hi_in = 1'b1; end
      A1_T3:   begin s.grb = 1'b1; s.r_out = 1'b1; s.zlo_in = 1'b1; op_dec = op_q; end
      LD_T3, ST_T3: begin s.grb = 1'b1; s.ba_out = 1'b1; s.y_in = 1'b1; end
      LD_T4, ST_T4: begin s.c_out = 1'b1; s.zlo_in = 1'b1; op_dec = OPW'(5'b00011); end
      LD_T5, ST_T5: begin s.zlow_out = 1'b1; s.mar_in = 1'b1; end
      LD_T6:   begin s.rd = 1'b1; s.mdr_in = 1'b1; end
      LD_T7:   begin s.mdr_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
      ST_T6:   begin s.gra = 1'b1; s.r_out = 1'b1; s.mdr_in = 1'b1; end
      ST_T7:   s.wr = 1'b1;
      ILLEGAL: ill_dec = 1'b1;
      default: ;
    endcase
  end

  // Strobes are ANDed with clr so FETCH0's decode never shows during reset.
  assign g          = clr ? s : '0;
  assign operation  = clr ? op_dec : '0;
  assign illegal_op = clr & ill_dec;
  assign run        = (state != HALT);

  assign PCout    = g.pc_out;    assign MARin   = g.mar_in;   assign IncPC  = g.inc_pc;
  assign PCin     = g.pc_in;     assign Read    = g.rd;       assign Write  = g.wr;
  assign MDRin    = g.mdr_in;    assign MDRout  = g.mdr_out;  assign IRin   = g.ir_in;
  assign Yin      = g.y_in;      assign ZHIin   = g.zhi_in;   assign ZLOin  = g.zlo_in;
  assign ZHighout = g.zhigh_out; assign ZLowout = g.zlow_out; assign HIin   = g.hi_in;
  assign LOin     = g.lo_in;     assign Cout    = g.c_out;    assign Gra    = g.gra;
  assign Grb      = g.grb;       assign Grc     = g.grc;      assign Rin    = g.r_in;
  assign Rout     = g.r_out;     assign BAout   = g.ba_out;

endmodule
